// File: rtl/axi_mport_bridge.sv
// axi_mport_bridge: round-robin read clients and one write client onto an AXI3 master with a write-line read hazard.
module axi_mport_bridge #(
  parameter int N_RD       = 3,
  parameter int LINE_WORDS = 4,
  parameter int WR_ID      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_RD-1:0]            rd_req,
  input  logic [N_RD-1:0]            rd_uncache,
  input  logic [3*N_RD-1:0]          rd_size,
  input  logic [32*N_RD-1:0]         rd_addr,
  output logic [N_RD-1:0]            rd_rdy,
  output logic [N_RD-1:0]            ret_valid,
  output logic [32*LINE_WORDS-1:0]   ret_data,
  input  logic                       wr_req,
  input  logic                       wr_uncache,
  input  logic [2:0]                 wr_size,
  input  logic [3:0]                 wr_wstrb,
  input  logic [31:0]                wr_addr,
  input  logic [32*LINE_WORDS-1:0]   wr_data,
  output logic                       wr_rdy,
  output logic                       wr_bvalid,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic [1:0]                 arlock,
  output logic [3:0]                 arcache,
  output logic [2:0]                 arprot,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [3:0]                 awid,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic [1:0]                 awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [3:0]                 wid,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);
  localparam int OFF = $clog2(LINE_WORDS*4);
  localparam int GW  = N_RD > 1 ? $clog2(N_RD) : 1;
  localparam int KW  = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam logic [7:0] LEN = 8'(LINE_WORDS-1);
  localparam logic [N_RD-1:0] ONE_R = 1;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_t;
  r_state_t r_st;
  w_state_t w_st;
  logic [GW-1:0] rr, g, c, gnt;
  logic any;
  logic [N_RD-1:0] elig;
  logic [31:0] r_addr, w_addr;
  logic [2:0] r_size, w_size;
  logic r_unc, w_unc;
  logic [KW-1:0] rk, wk;
  logic [32*LINE_WORDS-1:0] w_data;
  logic [3:0] w_strb;
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp, w_size};
  // a read touching the line currently being written must wait for the write to finish
  always_comb begin
    elig = '0;
    for (int j = 0; j < N_RD; j++)
      elig[j] = rd_req[j] && !(w_st != W_IDLE && rd_addr[32*j+OFF +: 32-OFF] == w_addr[31:OFF]);
  end
  always_comb begin
    gnt = '0;
    any = 1'b0;
    c = '0;
    for (int i = N_RD-1; i >= 0; i--) begin
      c = GW'((int'(rr) + i) % N_RD);
      if (elig[c]) begin
        gnt = c;
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st <= R_IDLE;
      rr <= '0;
      g <= '0;
      r_addr <= '0;
      r_size <= '0;
      r_unc <= 1'b0;
      rk <= '0;
      ret_data <= '0;
      rd_rdy <= '0;
    end else begin
      rd_rdy <= '0;
      unique case (r_st)
        R_IDLE: if (any) begin
          r_st <= R_AR;
          g <= gnt;
          rr <= (int'(gnt) == N_RD-1) ? '0 : gnt + 1'b1;
          r_addr <= rd_addr[32*gnt +: 32];
          r_size <= rd_size[3*gnt +: 3];
          r_unc <= rd_uncache[gnt];
          rd_rdy <= ONE_R << gnt;
        end
        R_AR: if (arready) r_st <= R_DATA;
        R_DATA: if (rvalid) begin
          ret_data[32*rk +: 32] <= rdata;
          rk <= rlast ? '0 : (rk == KW'(LINE_WORDS-1)) ? rk : rk + 1'b1;
          if (rlast) r_st <= R_RET;
        end
        R_RET: r_st <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_st <= W_IDLE;
      w_addr <= '0;
      w_data <= '0;
      w_size <= '0;
      w_strb <= '0;
      w_unc <= 1'b0;
      wk <= '0;
      wr_rdy <= 1'b0;
      wr_bvalid <= 1'b0;
    end else begin
      wr_rdy <= 1'b0;
      wr_bvalid <= 1'b0;
      unique case (w_st)
        W_IDLE: if (wr_req) begin
          w_st <= W_AW;
          w_addr <= wr_addr;
          w_data <= wr_data;
          w_size <= wr_size;
          w_strb <= wr_wstrb;
          w_unc <= wr_uncache;
          wr_rdy <= 1'b1;
        end
        W_AW: if (awready) w_st <= W_DATA;
        W_DATA: if (wready) begin
          wk <= wlast ? '0 : wk + 1'b1;
          if (wlast) w_st <= W_B;
        end
        W_B: if (bvalid) begin
          w_st <= W_IDLE;
          wr_bvalid <= 1'b1;
        end
      endcase
    end
  end
  assign ret_valid = (r_st == R_RET) ? ONE_R << g : '0;
  assign arid = 4'(g);
  assign araddr = r_unc ? r_addr : {r_addr[31:OFF], {OFF{1'b0}}};
  assign arlen = r_unc ? 8'd0 : LEN;
  assign arsize = r_unc ? r_size : 3'd2;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  assign arvalid = r_st == R_AR;
  assign rready = r_st == R_DATA;
  assign awid = 4'(WR_ID);
  assign awaddr = w_unc ? w_addr : {w_addr[31:OFF], {OFF{1'b0}}};
  assign awlen = w_unc ? 8'd0 : LEN;
  assign awsize = w_unc ? w_size : 3'd2;
  assign awburst = 2'b01;
  assign awlock = 2'b00;
  assign awcache = 4'd0;
  assign awprot = 3'd0;
  assign awvalid = w_st == W_AW;
  assign wid = 4'(WR_ID);
  assign wdata = w_data[32*wk +: 32];
  assign wstrb = w_unc ? w_strb : 4'hf;
  assign wlast = w_st == W_DATA && (w_unc || wk == KW'(LINE_WORDS-1));
  assign wvalid = w_st == W_DATA;
  assign bready = w_st == W_B;
endmodule

// File: doc/axi_mport_bridge.md
AXI_MPORT_BRIDGE -- requirements
Module: axi_mport_bridge

Interface
REQ-001 Parameter N_RD, default 3: number of read clients (1..8).
REQ-002 Parameter LINE_WORDS, default 4: 32-bit words per cache line, power of two, 1..16.
REQ-003 Parameter WR_ID, default 1: constant awid/wid value.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rd_req / rd_uncache  in  N_RD each  per-client read request / uncached flag.
REQ-007 rd_size  in  3*N_RD  per-client AXI size for uncached reads.
REQ-008 rd_addr  in  32*N_RD  per-client byte address.
REQ-009 rd_rdy  out  N_RD  request-accepted pulse.
REQ-010 ret_valid  out  N_RD  data-return pulse; ret_data  out  32*LINE_WORDS  shared line buffer.
REQ-011 wr_req, wr_uncache  in  1 each; wr_size  in  3; wr_wstrb  in  4; wr_addr  in  32; wr_data  in  32*LINE_WORDS.
REQ-012 wr_rdy  out  1  write accepted; wr_bvalid  out  1  write response pulse.
REQ-013 AXI master ar/r/aw/w/b channels, AXI3 widths: arid/awid/wid/rid/bid 4, addr 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3, data 32, wstrb 4, resp 2.

Function
REQ-014 Read FSM states R_IDLE, R_AR, R_DATA, R_RET; write FSM states W_IDLE, W_AW, W_DATA, W_B; both independent, one outstanding transaction each.
REQ-015 R_IDLE: round-robin grant over eligible rd_req bits, search starting at pointer rr; rr becomes grant+1 (mod N_RD) on grant.
REQ-016 On grant: rd_rdy[grant]=1 for exactly that cycle; addr/size/uncache latched; next state R_AR.
REQ-017 Cached read: araddr = addr with low log2(LINE_WORDS*4) bits cleared, arlen=LINE_WORDS-1, arsize=2, arburst=2'b01.
REQ-018 Uncached read: araddr = addr unmodified, arlen=0, arsize=latched rd_size, arburst=2'b01.
REQ-019 arid = grant index; arlock, arcache, arprot = 0.
REQ-020 arvalid=1 only in R_AR, held with stable payload until arready; then R_DATA.
REQ-021 R_DATA: rready=1; beat k (counter from 0) stored to ret_data word k; rresp and rid ignored.
REQ-022 Beat with rlast=1 -> R_RET; counter wraps never (limited to LINE_WORDS-1).
REQ-023 R_RET: ret_valid[grant]=1 for one cycle, ret_data stable that cycle; -> R_IDLE; new grant earliest next cycle.
REQ-024 Write accept in W_IDLE when wr_req=1: wr_rdy pulses one cycle; addr, data, size, wstrb, uncache latched; -> W_AW.
REQ-025 Cached write: awaddr line-aligned, awlen=LINE_WORDS-1, awsize=2, wstrb=4'hf; uncached: awaddr unmodified, awlen=0, awsize=wr_size, wstrb=wr_wstrb.
REQ-026 awvalid held in W_AW until awready -> W_DATA; wvalid=1 in W_DATA, wdata=word k, wlast=1 on beat awlen; advance k on wready; last handshake -> W_B.
REQ-027 W_B: bready=1; on bvalid, wr_bvalid=1 one cycle, -> W_IDLE.
REQ-028 Hazard: while write FSM not in W_IDLE, a read request whose line address (addr above line offset) equals the latched write line address is ineligible for grant; other requests still granted.
REQ-029 arvalid and awvalid may be asserted in the same cycle; no ordering imposed between channels other than REQ-028.
REQ-030 rd_req deassertion after acceptance does not cancel the transaction.

Reset
REQ-031 While reset=1: both FSMs idle, rr=0, counters 0, ret_data 0, all valid/ready/pulse outputs 0, latched payload registers 0.
REQ-032 Reset asserted mid-burst aborts immediately with no ret_valid/wr_bvalid; first request after release restarts from idle.

Verification
REQ-033 Clients 0 and 2 request together from reset -> client 0 granted first, client 2 next; arid 0 then 2.
REQ-034 Cached read 0x1FC0_0014, LINE_WORDS=4 -> araddr 0x1FC0_0010, arlen 3, four beats, ret_valid one cycle with words in beat order.
REQ-035 Uncached read size 1 at 0xBFAF_F002 -> araddr unchanged, arlen 0, arsize 1, word 0 holds rdata.
REQ-036 Cached write to 0x0000_1000 pending, read 0x0000_100C requested -> no arvalid until after wr_bvalid; read 0x0000_2000 meanwhile granted.
REQ-037 Uncached write wstrb 4'b0011 with wready held low 5 cycles -> wvalid/wdata stable, wlast=1 on single beat, wr_bvalid after bvalid.
REQ-038 Reset pulse during beat 2 of a 4-beat read -> rready, arvalid 0 at once, no ret_valid, next request completes normally.
